// File: rtl/bd_rx_frame_buffer_if.sv
// Decoder-in / host-stream-out bundle for the receive frame buffer.
// The buffer sits on the slave side; the decoder/host environment drives the master side.
interface bd_rx_frame_buffer_if #(
    parameter int DATA_W       = 8,
    parameter int DEPTH_FRAMES = 4,
    parameter int CNT_W        = 8
);
    localparam int FC_W = $clog2(DEPTH_FRAMES + 1);

    logic              dec_valid;
    logic [DATA_W-1:0] dec_data;
    logic              dec_sof;
    logic              dec_err;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              rx_last;
    logic [FC_W-1:0]   frame_cnt;
    logic [CNT_W-1:0]  drop_cnt;
    logic              int_rx_host;
    logic              int_clr;

    modport slave (
        input  dec_valid, dec_data, dec_sof, dec_err, rx_ready, int_clr,
        output rx_data, rx_valid, rx_last, frame_cnt, drop_cnt, int_rx_host
    );

    modport master (
        output dec_valid, dec_data, dec_sof, dec_err, rx_ready, int_clr,
        input  rx_data, rx_valid, rx_last, frame_cnt, drop_cnt, int_rx_host
    );
endinterface

// File: rtl/bd_rx_frame_buffer.sv
// Receive frame buffer: packs decoded bytes into fixed-size frames, keeps whole frames only,
// and streams committed frames to the host first-word-fall-through with a sticky interrupt.
module bd_rx_frame_buffer #(
    parameter int DATA_W       = 8,
    parameter int FRAME_BYTES  = 2,
    parameter int DEPTH_FRAMES = 4,
    parameter int IRQ_THRESH   = 1,
    parameter int CNT_W        = 8
) (
    input  logic                   G_CLK_RX,
    input  logic                   reset,
    bd_rx_frame_buffer_if.slave    bus
);
    localparam int WORDS  = DEPTH_FRAMES * FRAME_BYTES;
    localparam int ADDR_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int IDX_W  = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam int SLOT_W = (DEPTH_FRAMES > 1) ? $clog2(DEPTH_FRAMES) : 1;
    localparam int FC_W   = $clog2(DEPTH_FRAMES + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(FRAME_BYTES - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(DEPTH_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, DISCARD} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [WORDS];
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [SLOT_W-1:0] wr_slot;
    logic [SLOT_W-1:0] rd_slot;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [FC_W-1:0]   frame_cnt;
    logic [FC_W-1:0]   cnt_nxt;
    logic [CNT_W-1:0]  drop_cnt;
    logic              int_rx_host;
    logic              free;
    logic              wr_byte;
    logic              drop;
    logic              commit;
    logic              rx_valid;
    logic              rx_last;
    logic              xfer;
    logic              rel;

    // Byte decode. In COLLECT a sof both drops the open frame and restarts it in the same slot.
    always_comb begin
        free    = (frame_cnt != FC_W'(DEPTH_FRAMES));
        wr_byte = 1'b0;
        drop    = 1'b0;
        if (bus.dec_valid) begin
            if (state == COLLECT) begin
                drop    = bus.dec_sof | bus.dec_err;
                wr_byte = !bus.dec_err;
            end else if (bus.dec_sof) begin
                drop    = bus.dec_err | !free;
                wr_byte = !(bus.dec_err | !free);
            end
        end
        wr_idx  = bus.dec_sof ? '0 : idx;
        commit  = wr_byte && (wr_idx == LAST_IDX);
        wr_addr = ADDR_W'(wr_slot) * ADDR_W'(FRAME_BYTES) + ADDR_W'(wr_idx);
    end

    assign rx_valid = (frame_cnt != '0);
    assign rx_last  = rx_valid && (rd_idx == LAST_IDX);
    assign rd_addr  = ADDR_W'(rd_slot) * ADDR_W'(FRAME_BYTES) + ADDR_W'(rd_idx);
    assign xfer     = rx_valid && bus.rx_ready;
    assign rel      = xfer && rx_last;

    always_comb begin
        cnt_nxt = frame_cnt;
        if (commit && !rel)
            cnt_nxt = frame_cnt + FC_W'(1);
        else if (!commit && rel)
            cnt_nxt = frame_cnt - FC_W'(1);
    end

    always_ff @(posedge G_CLK_RX) begin
        if (wr_byte)
            mem[wr_addr] <= bus.dec_data;
    end

    always_ff @(posedge G_CLK_RX or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= '0;
            wr_slot  <= '0;
            drop_cnt <= '0;
        end else if (bus.dec_valid) begin
            if (wr_byte) begin
                if (commit) begin
                    state   <= IDLE;
                    idx     <= '0;
                    wr_slot <= (wr_slot == LAST_SLOT) ? '0 : wr_slot + SLOT_W'(1);
                end else begin
                    state <= COLLECT;
                    idx   <= wr_idx + IDX_W'(1);
                end
            end else if (drop) begin
                state <= DISCARD;
            end
            if (drop && drop_cnt != '1)
                drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge G_CLK_RX or negedge reset) begin
        if (!reset) begin
            rd_idx      <= '0;
            rd_slot     <= '0;
            frame_cnt   <= '0;
            int_rx_host <= 1'b0;
        end else begin
            if (xfer) begin
                if (rx_last) begin
                    rd_idx  <= '0;
                    rd_slot <= (rd_slot == LAST_SLOT) ? '0 : rd_slot + SLOT_W'(1);
                end else begin
                    rd_idx <= rd_idx + IDX_W'(1);
                end
            end
            frame_cnt <= cnt_nxt;
            // A commit that leaves the count at or above threshold beats a clear on the same edge.
            if (commit && cnt_nxt >= FC_W'(IRQ_THRESH))
                int_rx_host <= 1'b1;
            else if (bus.int_clr)
                int_rx_host <= 1'b0;
        end
    end

    assign bus.rx_valid    = rx_valid;
    assign bus.rx_last     = rx_last;
    assign bus.rx_data     = rx_valid ? mem[rd_addr] : '0;
    assign bus.frame_cnt   = frame_cnt;
    assign bus.drop_cnt    = drop_cnt;
    assign bus.int_rx_host = int_rx_host;
endmodule

// File: tb/tb_bd_rx_frame_buffer.sv
// Directed bench for bd_rx_frame_buffer (FRAME_BYTES=2, DEPTH_FRAMES=4, IRQ_THRESH=1, CNT_W=8).
module tb_bd_rx_frame_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    bd_rx_frame_buffer_if #(.DATA_W(8), .DEPTH_FRAMES(4), .CNT_W(8)) bus ();

    bd_rx_frame_buffer #(
        .DATA_W(8), .FRAME_BYTES(2), .DEPTH_FRAMES(4), .IRQ_THRESH(1), .CNT_W(8)
    ) dut (
        .G_CLK_RX(clk),
        .reset   (rst_n),
        .bus     (bus)
    );

    task automatic idle_inputs();
        bus.dec_valid = 1'b0;
        bus.dec_data  = 8'h00;
        bus.dec_sof   = 1'b0;
        bus.dec_err   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        bus.rx_ready = 1'b0;
        bus.int_clr  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One decoder byte; returns 1 time unit after the edge that captured it.
    task automatic send(input logic [7:0] d, input logic s, input logic e);
        bus.dec_valid = 1'b1;
        bus.dec_data  = d;
        bus.dec_sof   = s;
        bus.dec_err   = e;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    // Accept one stream byte within a bounded number of cycles.
    task automatic recv(output logic [7:0] d, output logic l, output logic ok);
        ok = 1'b0;
        d  = 8'h00;
        l  = 1'b0;
        bus.rx_ready = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.rx_valid) begin
                d  = bus.rx_data;
                l  = bus.rx_last;
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        bus.rx_ready = 1'b0;
        bus.int_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid: got %b want 0", bus.rx_valid); end
        tests++; if (bus.rx_last !== 1'b0) begin fails++; $display("FAIL reset_rx_last: got %b want 0", bus.rx_last); end
        tests++; if (bus.rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data: got %h want 00", bus.rx_data); end
        tests++; if (bus.frame_cnt !== 3'd0) begin fails++; $display("FAIL reset_frame_cnt: got %0d want 0", bus.frame_cnt); end
        tests++; if (bus.drop_cnt !== 8'd0) begin fails++; $display("FAIL reset_drop_cnt: got %0d want 0", bus.drop_cnt); end
        tests++; if (bus.int_rx_host !== 1'b0) begin fails++; $display("FAIL reset_int: got %b want 0", bus.int_rx_host); end
    endtask

    task automatic test_basic();
        do_reset();
        bus.rx_ready = 1'b1;
        send(8'hA5, 1'b1, 1'b0);
        tests++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL basic_partial_hidden: got %b want 0", bus.rx_valid); end
        send(8'h3C, 1'b0, 1'b0);
        tests++; if (bus.rx_valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %b want 1", bus.rx_valid); end
        tests++; if (bus.rx_data !== 8'hA5) begin fails++; $display("FAIL basic_byte0: got %h want a5", bus.rx_data); end
        tests++; if (bus.rx_last !== 1'b0) begin fails++; $display("FAIL basic_last0: got %b want 0", bus.rx_last); end
        tests++; if (bus.frame_cnt !== 3'd1) begin fails++; $display("FAIL basic_cnt1: got %0d want 1", bus.frame_cnt); end
        tests++; if (bus.int_rx_host !== 1'b1) begin fails++; $display("FAIL basic_int: got %b want 1", bus.int_rx_host); end
        @(posedge clk); #1;
        tests++; if (bus.rx_data !== 8'h3C) begin fails++; $display("FAIL basic_byte1: got %h want 3c", bus.rx_data); end
        tests++; if (bus.rx_last !== 1'b1) begin fails++; $display("FAIL basic_last1: got %b want 1", bus.rx_last); end
        @(posedge clk); #1;
        bus.rx_ready = 1'b0;
        tests++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL basic_drained: got %b want 0", bus.rx_valid); end
        tests++; if (bus.frame_cnt !== 3'd0) begin fails++; $display("FAIL basic_cnt0: got %0d want 0", bus.frame_cnt); end
        tests++; if (bus.int_rx_host !== 1'b1) begin fails++; $display("FAIL basic_int_sticky: got %b want 1", bus.int_rx_host); end
        bus.int_clr = 1'b1;
        @(posedge clk); #1;
        bus.int_clr = 1'b0;
        tests++; if (bus.int_rx_host !== 1'b0) begin fails++; $display("FAIL basic_int_clr: got %b want 0", bus.int_rx_host); end
    endtask

    task automatic test_irq_set_wins();
        do_reset();
        bus.int_clr = 1'b1;
        send(8'h01, 1'b1, 1'b0);
        send(8'h02, 1'b0, 1'b0);
        tests++; if (bus.int_rx_host !== 1'b1) begin fails++; $display("FAIL irq_set_wins: got %b want 1", bus.int_rx_host); end
        @(posedge clk); #1;
        bus.int_clr = 1'b0;
        tests++; if (bus.int_rx_host !== 1'b0) begin fails++; $display("FAIL irq_clr_after: got %b want 0", bus.int_rx_host); end
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        logic       l, ok;
        logic [3:0] hi;
        do_reset();
        for (int f = 0; f < 5; f++) begin
            hi = 4'(f + 1);
            send({hi, 4'h0}, 1'b1, 1'b0);
            send({hi, 4'h1}, 1'b0, 1'b0);
        end
        tests++; if (bus.frame_cnt !== 3'd4) begin fails++; $display("FAIL ovf_cnt: got %0d want 4", bus.frame_cnt); end
        tests++; if (bus.drop_cnt !== 8'd1) begin fails++; $display("FAIL ovf_drop: got %0d want 1", bus.drop_cnt); end
        for (int f = 0; f < 4; f++) begin
            for (int b = 0; b < 2; b++) begin
                hi = 4'(f + 1);
                recv(d, l, ok);
                tests++;
                if (!ok || d !== {hi, 4'(b)} || l !== 1'(b))
                    begin fails++; $display("FAIL ovf_drain f%0d b%0d: got ok=%b %h last=%b want %h last=%0d", f, b, ok, d, l, {hi, 4'(b)}, b); end
            end
        end
        tests++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL ovf_empty: got %b want 0", bus.rx_valid); end
        send(8'h60, 1'b1, 1'b0);
        send(8'h61, 1'b0, 1'b0);
        recv(d, l, ok);
        tests++; if (!ok || d !== 8'h60 || l !== 1'b0) begin fails++; $display("FAIL ovf_after0: got ok=%b %h last=%b want 60 last=0", ok, d, l); end
        recv(d, l, ok);
        tests++; if (!ok || d !== 8'h61 || l !== 1'b1) begin fails++; $display("FAIL ovf_after1: got ok=%b %h last=%b want 61 last=1", ok, d, l); end
    endtask

    task automatic test_err_abort();
        logic [7:0] d;
        logic       l, ok, seen;
        do_reset();
        send(8'h11, 1'b1, 1'b0);
        send(8'h22, 1'b0, 1'b1);
        send(8'h33, 1'b0, 1'b0);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.rx_valid !== 1'b0) seen = 1'b1;
        end
        @(posedge clk); #1;
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL err_valid_rose: got 1 want 0"); end
        tests++; if (bus.drop_cnt !== 8'd1) begin fails++; $display("FAIL err_drop: got %0d want 1", bus.drop_cnt); end
        tests++; if (bus.frame_cnt !== 3'd0) begin fails++; $display("FAIL err_cnt: got %0d want 0", bus.frame_cnt); end
        send(8'h77, 1'b1, 1'b0);
        send(8'h88, 1'b0, 1'b0);
        tests++; if (bus.frame_cnt !== 3'd1) begin fails++; $display("FAIL err_recover_cnt: got %0d want 1", bus.frame_cnt); end
        recv(d, l, ok);
        tests++; if (!ok || d !== 8'h77) begin fails++; $display("FAIL err_recover0: got ok=%b %h want 77", ok, d); end
        recv(d, l, ok);
        tests++; if (!ok || d !== 8'h88 || l !== 1'b1) begin fails++; $display("FAIL err_recover1: got ok=%b %h last=%b want 88 last=1", ok, d, l); end
    endtask

    task automatic test_sof_restart();
        logic [7:0] d;
        logic       l, ok;
        do_reset();
        send(8'h11, 1'b1, 1'b0);
        send(8'h44, 1'b1, 1'b0);
        send(8'h55, 1'b0, 1'b0);
        tests++; if (bus.drop_cnt !== 8'd1) begin fails++; $display("FAIL restart_drop: got %0d want 1", bus.drop_cnt); end
        tests++; if (bus.frame_cnt !== 3'd1) begin fails++; $display("FAIL restart_cnt: got %0d want 1", bus.frame_cnt); end
        recv(d, l, ok);
        tests++; if (!ok || d !== 8'h44 || l !== 1'b0) begin fails++; $display("FAIL restart_b0: got ok=%b %h last=%b want 44 last=0", ok, d, l); end
        recv(d, l, ok);
        tests++; if (!ok || d !== 8'h55 || l !== 1'b1) begin fails++; $display("FAIL restart_b1: got ok=%b %h last=%b want 55 last=1", ok, d, l); end
        tests++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL restart_empty: got %b want 0", bus.rx_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        do_reset();
        send(8'hA1, 1'b1, 1'b0);
        send(8'hA2, 1'b0, 1'b0);
        bus.rx_ready = 1'b1;
        send(8'hB1, 1'b1, 1'b0);
        tests++; if (bus.rx_data !== 8'hA2 || bus.rx_last !== 1'b1) begin fails++; $display("FAIL b2b_a2: got %h last=%b want a2 last=1", bus.rx_data, bus.rx_last); end
        send(8'hB2, 1'b0, 1'b0);
        tests++; if (bus.frame_cnt !== 3'd1) begin fails++; $display("FAIL b2b_cnt_hold: got %0d want 1", bus.frame_cnt); end
        tests++; if (bus.rx_data !== 8'hB1 || bus.rx_last !== 1'b0) begin fails++; $display("FAIL b2b_b1: got %h last=%b want b1 last=0", bus.rx_data, bus.rx_last); end
        @(posedge clk); #1;
        tests++; if (bus.rx_data !== 8'hB2 || bus.rx_last !== 1'b1) begin fails++; $display("FAIL b2b_b2: got %h last=%b want b2 last=1", bus.rx_data, bus.rx_last); end
        @(posedge clk); #1;
        bus.rx_ready = 1'b0;
        tests++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL b2b_empty: got %b want 0", bus.rx_valid); end
        // Fill, release one slot, and reuse it on the very next cycle.
        for (int f = 0; f < 4; f++) begin
            d = 8'(8'hC0 + 2 * f);
            send(d, 1'b1, 1'b0);
            send(d + 8'h01, 1'b0, 1'b0);
        end
        bus.rx_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.rx_ready = 1'b0;
        tests++; if (bus.frame_cnt !== 3'd3) begin fails++; $display("FAIL reuse_cnt3: got %0d want 3", bus.frame_cnt); end
        send(8'hD0, 1'b1, 1'b0);
        send(8'hD1, 1'b0, 1'b0);
        tests++; if (bus.frame_cnt !== 3'd4) begin fails++; $display("FAIL reuse_cnt4: got %0d want 4", bus.frame_cnt); end
        tests++; if (bus.drop_cnt !== 8'd0) begin fails++; $display("FAIL reuse_drop: got %0d want 0", bus.drop_cnt); end
        tests++; if (bus.rx_data !== 8'hC2) begin fails++; $display("FAIL reuse_head: got %h want c2", bus.rx_data); end
    endtask

    task automatic test_random_ready();
        do_reset();
        fork
            begin : writer
                for (int f = 0; f < 20; f++) begin
                    int w = 0;
                    while (bus.frame_cnt == 3'd4 && w < 500) begin
                        @(posedge clk); #1;
                        w++;
                    end
                    if (w >= 500) begin tests++; fails++; $display("FAIL rand_writer_timeout frame %0d", f); end
                    send(8'(2 * f), 1'b1, 1'b0);
                    send(8'(2 * f + 1), 1'b0, 1'b0);
                end
            end
            begin : reader
                int         got = 0;
                int         cyc = 0;
                logic       pv = 1'b0, pr = 1'b0, pl = 1'b0;
                logic [7:0] pd = 8'h00;
                while (got < 40 && cyc < 3000) begin
                    bus.rx_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    if (pv && !pr) begin
                        tests++;
                        if (bus.rx_valid !== 1'b1 || bus.rx_data !== pd || bus.rx_last !== pl)
                            begin fails++; $display("FAIL rand_stall_stable: got v=%b %h last=%b want v=1 %h last=%b", bus.rx_valid, bus.rx_data, bus.rx_last, pd, pl); end
                    end
                    tests++;
                    if (bus.frame_cnt > 3'd4) begin fails++; $display("FAIL rand_cnt_bound: got %0d want <=4", bus.frame_cnt); end
                    if (bus.rx_valid && bus.rx_ready) begin
                        tests++;
                        if (bus.rx_data !== 8'(got) || bus.rx_last !== 1'(got % 2))
                            begin fails++; $display("FAIL rand_order: got %h last=%b want %h last=%0d", bus.rx_data, bus.rx_last, 8'(got), got % 2); end
                        got++;
                    end
                    pv = bus.rx_valid;
                    pr = bus.rx_ready;
                    pd = bus.rx_data;
                    pl = bus.rx_last;
                    @(posedge clk); #1;
                    cyc++;
                end
                bus.rx_ready = 1'b0;
                tests++;
                if (got != 40) begin fails++; $display("FAIL rand_count: got %0d bytes want 40", got); end
            end
        join
        tests++; if (bus.drop_cnt !== 8'd0) begin fails++; $display("FAIL rand_drop: got %0d want 0", bus.drop_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        logic       l, ok;
        do_reset();
        send(8'hE0, 1'b1, 1'b0);
        send(8'hE1, 1'b0, 1'b0);
        send(8'hF0, 1'b1, 1'b0);
        send(8'hF1, 1'b0, 1'b0);
        send(8'hCC, 1'b1, 1'b0);
        tests++; if (bus.frame_cnt !== 3'd2) begin fails++; $display("FAIL rmid_pre_cnt: got %0d want 2", bus.frame_cnt); end
        rst_n = 1'b0;
        #1;
        tests++; if (bus.rx_valid !== 1'b0 || bus.rx_last !== 1'b0 || bus.rx_data !== 8'h00)
            begin fails++; $display("FAIL rmid_stream: got v=%b last=%b %h want 0 0 00", bus.rx_valid, bus.rx_last, bus.rx_data); end
        tests++; if (bus.frame_cnt !== 3'd0) begin fails++; $display("FAIL rmid_cnt: got %0d want 0", bus.frame_cnt); end
        tests++; if (bus.int_rx_host !== 1'b0) begin fails++; $display("FAIL rmid_int: got %b want 0", bus.int_rx_host); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(8'hBB - 8'h11, 1'b1, 1'b0);
        send(8'hBB, 1'b0, 1'b0);
        recv(d, l, ok);
        tests++; if (!ok || d !== 8'hAA || l !== 1'b0) begin fails++; $display("FAIL rmid_aa: got ok=%b %h last=%b want aa last=0", ok, d, l); end
        recv(d, l, ok);
        tests++; if (!ok || d !== 8'hBB || l !== 1'b1) begin fails++; $display("FAIL rmid_bb: got ok=%b %h last=%b want bb last=1", ok, d, l); end
        tests++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL rmid_empty: got %b want 0", bus.rx_valid); end
        tests++; if (bus.drop_cnt !== 8'd0) begin fails++; $display("FAIL rmid_drop: got %0d want 0", bus.drop_cnt); end
    endtask

    task automatic test_drop_sat();
        do_reset();
        repeat (260) send(8'h00, 1'b1, 1'b1);
        tests++; if (bus.drop_cnt !== 8'hFF) begin fails++; $display("FAIL drop_saturate: got %0d want 255", bus.drop_cnt); end
        tests++; if (bus.frame_cnt !== 3'd0) begin fails++; $display("FAIL drop_sat_cnt: got %0d want 0", bus.frame_cnt); end
    endtask

    initial begin
        idle_inputs();
        bus.rx_ready = 1'b0;
        bus.int_clr  = 1'b0;
        test_reset();
        test_basic();
        test_irq_set_wins();
        test_overflow();
        test_err_abort();
        test_sof_restart();
        test_back_to_back();
        test_random_ready();
        test_reset_mid();
        test_drop_sat();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
